// File: rtl/ex_stage_md.sv
// ex_stage_md -- execute stage with operand forwarding and an iterative
// multiply/divide unit owning the HI/LO registers.
//
// Ports (summary):
//   clk, rst_n                      clock, synchronous active-low reset
//   RegDst_ex, ALUCode_ex           destination select, ALU operation
//   ALUSrcA_ex, ALUSrcB_ex          ALU operand muxing (Sa_ex / Imm_ex)
//   Imm_ex, Sa_ex                   immediate and shift amount
//   Rs/Rt/RdAddr_ex, Rs/RtData_ex   register addresses and file read data
//   ALUResult_mem, RegWriteData_wb  forwarding values from MEM / WB
//   RegWriteAddr_*, RegWrite_*      forwarding addresses / enables
//   md_start, md_op                 start MULT/MULTU/DIV/DIVU
//   md_rd_hi/lo, md_wr_hi/lo        MFHI/MFLO, MTHI/MTLO
//   RegWriteAddr_ex, ALUResult_ex   destination and result
//   MemWriteData_ex, ALU_A, ALU_B   forwarded Rt, ALU operands
//   md_stall                        freeze IF/ID/EX while the unit is busy
//   hi_q, lo_q                      architectural HI/LO
module ex_stage_md #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ALUCODE_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegDst_ex,
    input  logic [ALUCODE_W-1:0] ALUCode_ex,
    input  logic                 ALUSrcA_ex,
    input  logic                 ALUSrcB_ex,
    input  logic [DATA_W-1:0]    Imm_ex,
    input  logic [DATA_W-1:0]    Sa_ex,
    input  logic [ADDR_W-1:0]    RsAddr_ex,
    input  logic [ADDR_W-1:0]    RtAddr_ex,
    input  logic [ADDR_W-1:0]    RdAddr_ex,
    input  logic [DATA_W-1:0]    RsData_ex,
    input  logic [DATA_W-1:0]    RtData_ex,
    input  logic [DATA_W-1:0]    ALUResult_mem,
    input  logic [DATA_W-1:0]    RegWriteData_wb,
    input  logic [ADDR_W-1:0]    RegWriteAddr_mem,
    input  logic [ADDR_W-1:0]    RegWriteAddr_wb,
    input  logic                 RegWrite_mem,
    input  logic                 RegWrite_wb,
    input  logic                 md_start,
    input  logic [1:0]           md_op,
    input  logic                 md_rd_hi,
    input  logic                 md_rd_lo,
    input  logic                 md_wr_hi,
    input  logic                 md_wr_lo,
    output logic [ADDR_W-1:0]    RegWriteAddr_ex,
    output logic [DATA_W-1:0]    ALUResult_ex,
    output logic [DATA_W-1:0]    MemWriteData_ex,
    output logic [DATA_W-1:0]    ALU_A,
    output logic [DATA_W-1:0]    ALU_B,
    output logic                 md_stall,
    output logic [DATA_W-1:0]    hi_q,
    output logic [DATA_W-1:0]    lo_q
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int SH_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    // ALU operation codes as used by the decoder.
    localparam logic [ALUCODE_W-1:0] ALU_ADD  = ALUCODE_W'(4'd0);
    localparam logic [ALUCODE_W-1:0] ALU_ADDU = ALUCODE_W'(4'd1);
    localparam logic [ALUCODE_W-1:0] ALU_SUB  = ALUCODE_W'(4'd2);
    localparam logic [ALUCODE_W-1:0] ALU_SUBU = ALUCODE_W'(4'd3);
    localparam logic [ALUCODE_W-1:0] ALU_AND  = ALUCODE_W'(4'd4);
    localparam logic [ALUCODE_W-1:0] ALU_OR   = ALUCODE_W'(4'd5);
    localparam logic [ALUCODE_W-1:0] ALU_XOR  = ALUCODE_W'(4'd6);
    localparam logic [ALUCODE_W-1:0] ALU_NOR  = ALUCODE_W'(4'd7);
    localparam logic [ALUCODE_W-1:0] ALU_SLT  = ALUCODE_W'(4'd8);
    localparam logic [ALUCODE_W-1:0] ALU_SLTU = ALUCODE_W'(4'd9);
    localparam logic [ALUCODE_W-1:0] ALU_SLL  = ALUCODE_W'(4'd10);
    localparam logic [ALUCODE_W-1:0] ALU_SRL  = ALUCODE_W'(4'd11);
    localparam logic [ALUCODE_W-1:0] ALU_SRA  = ALUCODE_W'(4'd12);
    localparam logic [ALUCODE_W-1:0] ALU_LUI  = ALUCODE_W'(4'd13);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // MEM has priority over WB; register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_val,
        input logic              we_mem,
        input logic [ADDR_W-1:0] addr_mem,
        input logic [DATA_W-1:0] val_mem,
        input logic              we_wb,
        input logic [ADDR_W-1:0] addr_wb,
        input logic [DATA_W-1:0] val_wb
    );
        if (we_mem && (addr_mem != '0) && (addr_mem == src)) begin
            return val_mem;
        end else if (we_wb && (addr_wb != '0) && (addr_wb == src)) begin
            return val_wb;
        end else begin
            return rf_val;
        end
    endfunction

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;          // raw dividend, reused as HI on divide-by-zero
    logic [DATA_W-1:0]  b_q, b_d;          // divisor / multiplicand magnitude
    logic [DATA_W:0]    acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]  acc_lo_q, acc_lo_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [DATA_W-1:0]  hi_d, lo_d;

    logic [DATA_W-1:0]   rs_fwd_s, rt_fwd_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic [SH_W-1:0]     shamt_s;
    logic                md_signed_s;
    logic                md_stall_s;
    logic [DATA_W:0]     mul_sum_s, div_sh_s, div_trial_s;
    logic [DATA_W:0]     step_hi_s;
    logic [DATA_W-1:0]   step_lo_s;
    logic [2*DATA_W-1:0] prod_s, prod_fix_s;
    logic [DATA_W-1:0]   rem_mag_s;
    logic [DATA_W-1:0]   res_hi_s, res_lo_s;

    // Operand forwarding, ALU operand muxing and destination select.
    always_comb begin
        rs_fwd_s = fwd_sel(RsAddr_ex, RsData_ex, RegWrite_mem, RegWriteAddr_mem,
                           ALUResult_mem, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
        rt_fwd_s = fwd_sel(RtAddr_ex, RtData_ex, RegWrite_mem, RegWriteAddr_mem,
                           ALUResult_mem, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
        if (ALUSrcA_ex) ALU_A = Sa_ex;  else ALU_A = rs_fwd_s;
        if (ALUSrcB_ex) ALU_B = Imm_ex; else ALU_B = rt_fwd_s;
        if (RegDst_ex) RegWriteAddr_ex = RdAddr_ex; else RegWriteAddr_ex = RtAddr_ex;
        MemWriteData_ex = rt_fwd_s;
    end

    // ALU proper; shifts move ALU_B by the low bits of ALU_A.
    always_comb begin
        shamt_s   = ALU_A[SH_W-1:0];
        alu_res_s = '0;
        case (ALUCode_ex)
            ALU_ADD, ALU_ADDU: alu_res_s = ALU_A + ALU_B;
            ALU_SUB, ALU_SUBU: alu_res_s = ALU_A - ALU_B;
            ALU_AND:  alu_res_s = ALU_A & ALU_B;
            ALU_OR:   alu_res_s = ALU_A | ALU_B;
            ALU_XOR:  alu_res_s = ALU_A ^ ALU_B;
            ALU_NOR:  alu_res_s = ~(ALU_A | ALU_B);
            ALU_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(ALU_A) < $signed(ALU_B))};
            ALU_SLTU: alu_res_s = {{(DATA_W-1){1'b0}}, (ALU_A < ALU_B)};
            ALU_SLL:  alu_res_s = ALU_B << shamt_s;
            ALU_SRL:  alu_res_s = ALU_B >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(ALU_B) >>> shamt_s;
            ALU_LUI:  alu_res_s = {ALU_B[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default:  alu_res_s = '0;
        endcase
    end

    // Result mux: MFHI/MFLO replace the ALU result unless a start is present.
    always_comb begin
        if (md_rd_hi && !md_start) begin
            ALUResult_ex = hi_q;
        end else if (md_rd_lo && !md_start) begin
            ALUResult_ex = lo_q;
        end else begin
            ALUResult_ex = alu_res_s;
        end
    end

    // Stall while starting or iterating; HI/LO accesses in that window wait too.
    always_comb begin
        md_stall_s = ((state_q == MD_IDLE) && md_start)
                   || (state_q == MD_BUSY)
                   || (((state_q == MD_BUSY) || ((state_q == MD_IDLE) && md_start))
                       && (md_rd_hi || md_rd_lo || md_wr_hi || md_wr_lo));
        if (rst_n) begin
            md_stall = md_stall_s;
        end else begin
            md_stall = 1'b0;
        end
    end

    // One radix-2 step: shift-add multiply or restoring divide, on magnitudes.
    always_comb begin
        mul_sum_s   = acc_hi_q + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        div_sh_s    = {acc_hi_q[DATA_W-1:0], acc_lo_q[DATA_W-1]};
        div_trial_s = div_sh_s - {1'b0, b_q};
        if (op_q[1]) begin
            if (!div_trial_s[DATA_W]) begin
                step_hi_s = div_trial_s;
                step_lo_s = {acc_lo_q[DATA_W-2:0], 1'b1};
            end else begin
                step_hi_s = div_sh_s;
                step_lo_s = {acc_lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            step_hi_s = {1'b0, mul_sum_s[DATA_W:1]};
            step_lo_s = {mul_sum_s[0], acc_lo_q[DATA_W-1:1]};
        end
    end

    // Sign correction of the final step; divide-by-zero bypasses it.
    always_comb begin
        prod_s     = {step_hi_s[DATA_W-1:0], step_lo_s};
        prod_fix_s = neg_res_q ? -prod_s : prod_s;
        rem_mag_s  = step_hi_s[DATA_W-1:0];
        if (!op_q[1]) begin
            res_hi_s = prod_fix_s[2*DATA_W-1:DATA_W];
            res_lo_s = prod_fix_s[DATA_W-1:0];
        end else if (div0_q) begin
            res_hi_s = a_q;
            res_lo_s = '1;
        end else begin
            res_hi_s = neg_rem_q ? -rem_mag_s : rem_mag_s;
            res_lo_s = neg_res_q ? -step_lo_s : step_lo_s;
        end
    end

    // Multiply/divide sequencing and HI/LO update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        div0_d      = div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_signed_s = !md_op[0];
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if ((state_q == MD_IDLE) && md_start) begin
                    state_d   = MD_BUSY;
                    cnt_d     = CNT_INIT;
                    op_d      = md_op;
                    a_d       = rs_fwd_s;
                    b_d       = (md_signed_s && rt_fwd_s[DATA_W-1]) ? -rt_fwd_s : rt_fwd_s;
                    acc_hi_d  = '0;
                    acc_lo_d  = (md_signed_s && rs_fwd_s[DATA_W-1]) ? -rs_fwd_s : rs_fwd_s;
                    neg_res_d = md_signed_s && (rs_fwd_s[DATA_W-1] ^ rt_fwd_s[DATA_W-1]);
                    neg_rem_d = md_signed_s && rs_fwd_s[DATA_W-1];
                    div0_d    = md_op[1] && (rt_fwd_s == '0);
                end else begin
                    state_d = MD_IDLE;
                    if (!md_stall_s && !md_start && md_wr_hi) hi_d = rs_fwd_s; else hi_d = hi_q;
                    if (!md_stall_s && !md_start && md_wr_lo) lo_d = rs_fwd_s; else lo_d = lo_q;
                end
            end
            MD_BUSY: begin
                acc_hi_d = step_hi_s;
                acc_lo_d = step_lo_s;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = res_hi_s;
                    lo_d    = res_lo_s;
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Testbench for ex_stage_md: randomized and directed stimulus, expected
// responses queued by the stimulus and checked by an independent monitor.
module tb_ex_stage_md;

    logic        clk;
    logic        rst_n;
    logic        RegDst_ex;
    logic [4:0]  ALUCode_ex;
    logic        ALUSrcA_ex, ALUSrcB_ex;
    logic [31:0] Imm_ex, Sa_ex;
    logic [4:0]  RsAddr_ex, RtAddr_ex, RdAddr_ex;
    logic [31:0] RsData_ex, RtData_ex;
    logic [31:0] ALUResult_mem, RegWriteData_wb;
    logic [4:0]  RegWriteAddr_mem, RegWriteAddr_wb;
    logic        RegWrite_mem, RegWrite_wb;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_rd_hi, md_rd_lo, md_wr_hi, md_wr_lo;
    logic [4:0]  RegWriteAddr_ex;
    logic [31:0] ALUResult_ex, MemWriteData_ex, ALU_A, ALU_B;
    logic        md_stall;
    logic [31:0] hi_q, lo_q;

    ex_stage_md #(.DATA_W(32), .ADDR_W(5), .ALUCODE_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .RegDst_ex(RegDst_ex), .ALUCode_ex(ALUCode_ex),
        .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex), .Imm_ex(Imm_ex), .Sa_ex(Sa_ex),
        .RsAddr_ex(RsAddr_ex), .RtAddr_ex(RtAddr_ex), .RdAddr_ex(RdAddr_ex),
        .RsData_ex(RsData_ex), .RtData_ex(RtData_ex), .ALUResult_mem(ALUResult_mem),
        .RegWriteData_wb(RegWriteData_wb), .RegWriteAddr_mem(RegWriteAddr_mem),
        .RegWriteAddr_wb(RegWriteAddr_wb), .RegWrite_mem(RegWrite_mem), .RegWrite_wb(RegWrite_wb),
        .md_start(md_start), .md_op(md_op), .md_rd_hi(md_rd_hi), .md_rd_lo(md_rd_lo),
        .md_wr_hi(md_wr_hi), .md_wr_lo(md_wr_lo), .RegWriteAddr_ex(RegWriteAddr_ex),
        .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex), .ALU_A(ALU_A),
        .ALU_B(ALU_B), .md_stall(md_stall), .hi_q(hi_q), .lo_q(lo_q)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          chk_res;
    } md_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] mwd;
        logic [4:0]  dst;
    } comb_exp_t;

    md_exp_t   md_q[$];
    comb_exp_t comb_q[$];
    int        tests = 0;
    int        fails = 0;
    logic      probe = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Operand selection: MEM beats WB, register 0 never forwarded.
    function automatic logic [31:0] pick(input logic [4:0] src, input logic [31:0] rf);
        if (RegWrite_mem && RegWriteAddr_mem != 5'd0 && RegWriteAddr_mem == src) return ALUResult_mem;
        if (RegWrite_wb && RegWriteAddr_wb != 5'd0 && RegWriteAddr_wb == src) return RegWriteData_wb;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [4:0] code, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(a[4:0]);
        case (code)
            5'd0, 5'd1: return a + b;
            5'd2, 5'd3: return a - b;
            5'd4:  return a & b;
            5'd5:  return a | b;
            5'd6:  return a ^ b;
            5'd7:  return ~(a | b);
            5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  return (a < b) ? 32'd1 : 32'd0;
            5'd10: return b << sh;
            5'd11: return b >> sh;
            5'd12: return $signed(b) >>> sh;
            5'd13: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // Arithmetic reference: 64-bit products and language division semantics.
    task automatic md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) begin
            p = 64'(sa * sb);
            hi = p[63:32]; lo = p[31:0];
        end else if (op == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 2'b10) begin
            q = sa / sb; r = sa % sb;
            p = 64'(q); lo = p[31:0];
            p = 64'(r); hi = p[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic set_idle();
        RegDst_ex = 1'b0; ALUCode_ex = 5'd0; ALUSrcA_ex = 1'b0; ALUSrcB_ex = 1'b0;
        Imm_ex = 32'd0; Sa_ex = 32'd0; RsAddr_ex = 5'd0; RtAddr_ex = 5'd0; RdAddr_ex = 5'd0;
        RsData_ex = 32'd0; RtData_ex = 32'd0; ALUResult_mem = 32'd0; RegWriteData_wb = 32'd0;
        RegWriteAddr_mem = 5'd0; RegWriteAddr_wb = 5'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
        md_start = 1'b0; md_op = 2'b00; md_rd_hi = 1'b0; md_rd_lo = 1'b0;
        md_wr_hi = 1'b0; md_wr_lo = 1'b0;
    endtask

    // Queue the expected combinational response to the inputs now applied.
    task automatic push_comb();
        comb_exp_t e;
        logic [31:0] rs, rt;
        rs = pick(RsAddr_ex, RsData_ex);
        rt = pick(RtAddr_ex, RtData_ex);
        e.a   = ALUSrcA_ex ? Sa_ex : rs;
        e.b   = ALUSrcB_ex ? Imm_ex : rt;
        e.res = alu_model(ALUCode_ex, e.a, e.b);
        e.mwd = rt;
        e.dst = RegDst_ex ? RdAddr_ex : RtAddr_ex;
        comb_q.push_back(e);
        probe = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    // Issue one MULT/DIV; md_start is held until the stall drops (DONE cycle).
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit rd_after, input logic [1:0] fwd);
        md_exp_t e;
        bit done;
        @(posedge clk); #1;
        set_idle();
        md_op = op; md_start = 1'b1; RsAddr_ex = 5'd1; RtAddr_ex = 5'd2;
        if (fwd[0]) begin
            RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd1; ALUResult_mem = a; RsData_ex = ~a;
        end else begin
            RsData_ex = a;
        end
        if (fwd[1]) begin
            RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd2; RegWriteData_wb = b; RtData_ex = ~b;
        end else begin
            RtData_ex = b;
        end
        md_model(op, a, b, e.hi, e.lo);
        e.chk_res = rd_after;
        md_q.push_back(e);
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!md_stall) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rd_after) begin
                md_start = 1'b0;
                md_rd_lo = 1'b1;
            end
        end
        if (!done) begin
            fails++;
            $display("FAIL md_timeout: stall still high after 60 cycles");
        end
        @(posedge clk); #1;
        md_start = 1'b0;
        md_rd_lo = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: combinational checks on probe, MD checks when a stall run ends.
    initial begin
        int        run;
        md_exp_t   m;
        comb_exp_t c;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (md_stall) begin
                run++;
            end else begin
                if (probe) begin
                    if (comb_q.size() == 0) begin
                        fails++;
                        $display("FAIL comb_unexpected: probe with empty queue");
                    end else begin
                        c = comb_q.pop_front();
                        check("alu_a", 64'(ALU_A), 64'(c.a));
                        check("alu_b", 64'(ALU_B), 64'(c.b));
                        check("alu_result", 64'(ALUResult_ex), 64'(c.res));
                        check("mem_wdata", 64'(MemWriteData_ex), 64'(c.mwd));
                        check("dest_addr", 64'(RegWriteAddr_ex), 64'(c.dst));
                    end
                end
                if (run != 0) begin
                    if (md_q.size() == 0) begin
                        fails++;
                        $display("FAIL md_unexpected: stall run of %0d cycles, none expected", run);
                    end else begin
                        m = md_q.pop_front();
                        check("md_stall_len", 64'(run), 64'd33);
                        check("md_hi", 64'(hi_q), 64'(m.hi));
                        check("md_lo", 64'(lo_q), 64'(m.lo));
                        if (m.chk_res) check("mflo_result", 64'(ALUResult_ex), 64'(m.lo));
                    end
                    run = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall_low", 64'(md_stall), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall", 64'(md_stall), 64'd0);
        check("rst_hi", 64'(hi_q), 64'd0);
        check("rst_lo", 64'(lo_q), 64'd0);

        // Forwarding priority: MEM over WB, and register 0 never forwarded.
        @(posedge clk); #1;
        set_idle();
        RsAddr_ex = 5'd5; RsData_ex = 32'h55;
        RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd5; ALUResult_mem = 32'hA;
        RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd5; RegWriteData_wb = 32'hB;
        push_comb();
        RsAddr_ex = 5'd0; RegWriteAddr_mem = 5'd0; RegWriteAddr_wb = 5'd0;
        push_comb();
        RsAddr_ex = 5'd7; RegWriteAddr_wb = 5'd7; RegWriteAddr_mem = 5'd3;
        push_comb();

        // Randomized ALU / forwarding / mux vectors.
        for (int i = 0; i < 24; i++) begin
            RegDst_ex = 1'($urandom_range(0, 1));
            ALUCode_ex = 5'($urandom_range(0, 15));
            ALUSrcA_ex = 1'($urandom_range(0, 1));
            ALUSrcB_ex = 1'($urandom_range(0, 1));
            Imm_ex = $urandom; Sa_ex = 32'($urandom_range(0, 31));
            RsAddr_ex = 5'($urandom_range(0, 7)); RtAddr_ex = 5'($urandom_range(0, 7));
            RdAddr_ex = 5'($urandom_range(0, 31));
            RsData_ex = $urandom; RtData_ex = $urandom;
            ALUResult_mem = $urandom; RegWriteData_wb = $urandom;
            RegWriteAddr_mem = 5'($urandom_range(0, 7)); RegWriteAddr_wb = 5'($urandom_range(0, 7));
            RegWrite_mem = 1'($urandom_range(0, 1)); RegWrite_wb = 1'($urandom_range(0, 1));
            push_comb();
        end

        // Directed multiply / divide corner cases.
        run_md(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 2'b00);
        run_md(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b01);
        run_md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b10);
        run_md(2'b11, 32'd7, 32'd0, 1'b0, 2'b00);
        run_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b11);
        run_md(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 2'b00);
        run_md(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 2'b00);

        // Randomized multiply / divide with random forwarding.
        for (int i = 0; i < 10; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_md(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)));
        end

        // MTHI / MTLO (with MEM forwarding) and MFHI.
        @(posedge clk); #1;
        set_idle();
        RsAddr_ex = 5'd3; RsData_ex = 32'h1234; md_wr_hi = 1'b1;
        @(negedge clk);
        check("mthi_no_stall", 64'(md_stall), 64'd0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("mthi_hi", 64'(hi_q), 64'h1234);
        @(posedge clk); #1;
        RsAddr_ex = 5'd4; RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd4;
        ALUResult_mem = 32'hCAFE; md_wr_lo = 1'b1;
        @(posedge clk); #1;
        set_idle();
        md_rd_hi = 1'b1;
        @(negedge clk);
        check("mtlo_lo", 64'(lo_q), 64'hCAFE);
        check("mfhi_result", 64'(ALUResult_ex), 64'h1234);

        // Reset in the middle of an iteration (counter at 10).
        @(posedge clk); #1;
        set_idle();
        md_start = 1'b1; md_op = 2'b00; RsData_ex = 32'd5; RtData_ex = 32'd9;
        repeat (23) @(posedge clk);
        #1;
        rst_n = 1'b0;
        md_start = 1'b0;
        @(negedge clk);
        check("midrst_stall_in_reset", 64'(md_stall), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_stall", 64'(md_stall), 64'd0);
        check("midrst_hi", 64'(hi_q), 64'd0);
        check("midrst_lo", 64'(lo_q), 64'd0);

        // Unit behaves normally after the reset.
        run_md(2'b00, 32'd12, 32'hFFFF_FFFE, 1'b0, 2'b00);
        repeat (3) @(negedge clk);

        if (md_q.size() != 0) begin
            fails++;
            $display("FAIL md_pending: %0d expected results never observed", md_q.size());
        end
        if (comb_q.size() != 0) begin
            fails++;
            $display("FAIL comb_pending: %0d expected results never observed", comb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
